// File: rtl/bcd_serial_adder_ctrl.sv
// Bit-serial multi-digit BCD adder sequencer driving one external 1-bit full adder.
// Each digit gets a 4-cycle binary pass, then an optional 4-cycle +0110 correction pass.
// Optional macro BCD_INPUT_CHECK_EN: flags operands containing a digit > 9 on Start acceptance.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  cin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  cout_o,
  output logic                  err_o,
  output logic                  fa_a_o,
  output logic                  fa_b_o,
  output logic                  fa_cin_o,
  input  logic                  fa_sum_i,
  input  logic                  fa_cout_i
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned IW = $clog2(W);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
  localparam logic [3:0]    SIX        = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   digit_q;
  logic [1:0]      bit_q;
  logic            carry_q;
  logic            dcarry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  logic [IW-1:0]   idx;
  logic [IW-1:0]   base;
  logic [3:0]      dig_s;
  logic            corr;
  logic            last_digit;

  assign idx        = IW'({digit_q, bit_q});
  assign base       = IW'({digit_q, 2'b00});
  assign dig_s      = {fa_sum_i, sum_q[base +: 3]};
  assign corr       = fa_cout_i | (dig_s > 4'd9);
  assign last_digit = (digit_q == LAST_DIGIT);

  // Route the current bit of the active pass to the shared full adder.
  always_comb begin
    fa_a_o   = 1'b0;
    fa_b_o   = 1'b0;
    fa_cin_o = 1'b0;
    case (state_q)
      S_ADD: begin
        fa_a_o   = a_q[idx];
        fa_b_o   = b_q[idx];
        fa_cin_o = carry_q;
      end
      S_CORR: begin
        fa_a_o   = sum_q[idx];
        fa_b_o   = SIX[bit_q];
        fa_cin_o = carry_q;
      end
      default: ;
    endcase
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_q;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Invalid-digit flag, refreshed on every accepted Start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      err_q <= has_bad_digit(a_i) | has_bad_digit(b_i);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Sequencer: phase/counter state, operand and result registers, registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      digit_q  <= '0;
      bit_q    <= '0;
      carry_q  <= 1'b0;
      dcarry_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            carry_q  <= cin_i;
            digit_q  <= '0;
            bit_q    <= '0;
            dcarry_q <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q[idx] <= fa_sum_i;
          carry_q    <= fa_cout_i;
          bit_q      <= bit_q + 2'd1;
          if (bit_q == 2'd3) begin
            carry_q <= 1'b0;
            if (corr) begin
              dcarry_q <= 1'b1;
              state_q  <= S_CORR;
            end else begin
              dcarry_q <= 1'b0;
              if (last_digit) begin
                cout_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                digit_q <= digit_q + DW'(1);
              end
            end
          end
        end
        S_CORR: begin
          sum_q[idx] <= fa_sum_i;
          carry_q    <= fa_cout_i;
          bit_q      <= bit_q + 2'd1;
          if (bit_q == 2'd3) begin
            // Correction carry is discarded; the decimal carry feeds the next digit.
            carry_q <= dcarry_q;
            if (last_digit) begin
              cout_q  <= dcarry_q;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              digit_q <= digit_q + DW'(1);
              state_q <= S_ADD;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl with an external full adder cell.
module tb_bcd_serial_adder_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy_o, done_o, cout_o, err_o;
  logic [W-1:0] sum_o;
  logic         fa_a_o, fa_b_o, fa_cin_o;
  logic         fa_sum_i, fa_cout_i;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           lat;
    longint       start_cyc;
  } exp_t;

  exp_t sb[$];

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .sum_o    (sum_o),
    .cout_o   (cout_o),
    .err_o    (err_o),
    .fa_a_o   (fa_a_o),
    .fa_b_o   (fa_b_o),
    .fa_cin_o (fa_cin_o),
    .fa_sum_i (fa_sum_i),
    .fa_cout_i(fa_cout_i)
  );

  // External shared full adder cell.
  assign fa_sum_i  = fa_a_o ^ fa_b_o ^ fa_cin_o;
  assign fa_cout_i = (fa_a_o & fa_b_o) | (fa_cin_o & (fa_a_o ^ fa_b_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digit-wise decimal addition with carry, plus cycle cost.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    int   c, k, t, da, db;
    logic bad;
    c = int'(cin);
    k = 0;
    bad = 1'b0;
    e.sum = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1'b1;
      t = da + db + c;
      if (t > 9) begin
        t = (t + 6) % 16;
        c = 1;
        k++;
      end else begin
        c = 0;
      end
      e.sum[4*i +: 4] = 4'(t);
    end
    e.cout = (c != 0);
`ifdef BCD_INPUT_CHECK_EN
    e.err = bad;
`else
    e.err = 1'b0;
`endif
    e.lat = 4 * int'(DIGITS) + 4 * k + 1;
    e.start_cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < int'(DIGITS); i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Monitor: compare each Done against the oldest expected result.
  int busy_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required none");
        end else begin
          e = sb.pop_front();
          chk("sum",     64'(sum_o),  64'(e.sum));
          chk("cout",    64'(cout_o), 64'(e.cout));
          chk("err",     64'(err_o),  64'(e.err));
          chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
          chk("busy_at_done", 64'(busy_o), 64'(0));
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one operation; optionally pulse a conflicting Start mid-flight.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int mid_start);
    exp_t e;
    int   n;
    e = model(a, b, cin);
    e.start_cyc = cyc;
    sb.push_back(e);
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    cin_i = cin;
    @(negedge clk);
    start_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    cin_i = 1'($urandom);
    chk("busy_after_accept", 64'(busy_o), 64'(1));
    chk("err_after_accept", 64'(err_o), 64'(e.err));
    n = 1;
    while (!done_o && n < 200) begin
      if (n == mid_start) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d", n, e.lat);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      return;
    end
    @(negedge clk);
    chk("idle_done", 64'(done_o), 64'(0));
    chk("idle_fa", 64'({fa_a_o, fa_b_o, fa_cin_o}), 64'(0));
    chk("sum_hold", 64'(sum_o), 64'(e.sum));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    #1;
    chk("reset_outs", 64'({busy_o, done_o, cout_o, err_o, fa_a_o, fa_b_o, fa_cin_o}), 64'(0));
    chk("reset_sum", 64'(sum_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, -1);
    do_op(16'h0009, 16'h0001, 1'b0, -1);
    do_op(16'h0008, 16'h0009, 1'b0, -1);
    do_op(16'h9999, 16'h9999, 1'b1, -1);
    do_op(16'h0000, 16'h0000, 1'b0, -1);

    // Start during digit-2 ADD must be ignored.
    do_op(16'h1234, 16'h4321, 1'b0, 9);

    // Reset in the middle of the digit-0 correction pass.
    start_i = 1'b1;
    a_i = 16'h9999;
    b_i = 16'h9999;
    cin_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("corr_pass_fa_b", 64'(fa_b_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({busy_o, done_o, cout_o, err_o, fa_a_o, fa_b_o, fa_cin_o}), 64'(0));
    chk("abort_sum", 64'(sum_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_busy", 64'(busy_o), 64'(0));

    do_op(16'h5678, 16'h4321, 1'b1, -1);
    do_op(16'h00A0, 16'h0001, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      do_op(rand_bcd(), rand_bcd(), 1'($urandom), -1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
